hiss_rx_deser: RTL and testbench

//  Receive deserializer directly downstream of the HISS LVDS receiver pad cell. Consumes hiss_rxi/hiss_rxq
//  and runs on the recovered hiss_clk. Hunts for the frame sync pattern on the I lane, then converts I/Q

---
 rtl/hiss_rx_deser_if.sv | 30 +++
 rtl/hiss_rx_deser.sv | 160 ++++++++++++++++
 tb/tb_hiss_rx_deser.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/hiss_rx_deser_if.sv
// Signal bundle between the HISS receive pad cell / control side and the receive deserializer.
// The master side drives the serial lanes and enable; the slave (deserializer) returns words and status.
interface hiss_rx_deser_if #(
   parameter int WORD_W = 8
);
   logic              rx_en;
   logic              hiss_rxi;
   logic              hiss_rxq;
   logic              hiss_rxien;
   logic              hiss_rxqen;
   logic [WORD_W-1:0] rx_i_word;
   logic [WORD_W-1:0] rx_q_word;
   logic              rx_valid;
   logic              rx_sof;
   logic              locked;
   logic              sync_err;
   logic [7:0]        err_cnt;

   modport master (
      output rx_en, hiss_rxi, hiss_rxq,
      input  hiss_rxien, hiss_rxqen, rx_i_word, rx_q_word,
      input  rx_valid, rx_sof, locked, sync_err, err_cnt
   );

   modport slave (
      input  rx_en, hiss_rxi, hiss_rxq,
      output hiss_rxien, hiss_rxqen, rx_i_word, rx_q_word,
      output rx_valid, rx_sof, locked, sync_err, err_cnt
   );
endinterface

// File: rtl/hiss_rx_deser.sv
// HISS receive deserializer: hunts for the I-lane sync preamble, then deserializes I/Q word pairs
// frame by frame, re-checking the preamble between frames and dropping lock after MAX_MISS bad ones.
module hiss_rx_deser #(
   parameter int                WORD_W      = 8,
   parameter int                SYNC_W      = 8,
   parameter logic [SYNC_W-1:0] SYNC_PAT    = 8'hA5,
   parameter int                FRAME_WORDS = 4,
   parameter int                MAX_MISS    = 3
) (
   input  logic           i_hiss_clk,
   input  logic           i_n_reset,
   hiss_rx_deser_if.slave bus
);
   localparam int BIT_MAX = (WORD_W > SYNC_W) ? WORD_W : SYNC_W;
   localparam int CNT_W   = $clog2(BIT_MAX + 1);
   localparam int WC_W    = $clog2(FRAME_WORDS + 1);
   localparam int MC_W    = $clog2(MAX_MISS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HUNT,
      S_LOCKED,
      S_CHECK
   } state_t;

   state_t              r_state;
   logic [SYNC_W-1:0]   r_sync_sreg;
   logic [WORD_W-1:0]   r_word_i;
   logic [WORD_W-1:0]   r_word_q;
   logic [CNT_W-1:0]    r_bit_cnt;
   logic [WC_W-1:0]     r_word_cnt;
   logic [MC_W-1:0]     r_miss_cnt;
   logic [WORD_W-1:0]   r_rx_i_word;
   logic [WORD_W-1:0]   r_rx_q_word;
   logic                r_rx_valid;
   logic                r_rx_sof;
   logic                r_locked;
   logic                r_sync_err;
   logic [7:0]          r_err_cnt;

   logic [SYNC_W-1:0]   w_sync_shift;
   logic [WORD_W-1:0]   w_i_shift;
   logic [WORD_W-1:0]   w_q_shift;
   logic [MC_W-1:0]     w_miss_inc;
   logic                w_word_last;
   logic                w_sync_last;

   // Candidate values including the bit being sampled this edge
   assign w_sync_shift = {r_sync_sreg[SYNC_W-2:0], bus.hiss_rxi};
   assign w_i_shift    = {r_word_i[WORD_W-2:0], bus.hiss_rxi};
   assign w_q_shift    = {r_word_q[WORD_W-2:0], bus.hiss_rxq};
   assign w_miss_inc   = r_miss_cnt + 1'b1;
   assign w_word_last  = (r_bit_cnt == CNT_W'(WORD_W - 1));
   assign w_sync_last  = (r_bit_cnt == CNT_W'(SYNC_W - 1));

   assign bus.hiss_rxien = bus.rx_en;
   assign bus.hiss_rxqen = bus.rx_en;
   assign bus.rx_i_word  = r_rx_i_word;
   assign bus.rx_q_word  = r_rx_q_word;
   assign bus.rx_valid   = r_rx_valid;
   assign bus.rx_sof     = r_rx_sof;
   assign bus.locked     = r_locked;
   assign bus.sync_err   = r_sync_err;
   assign bus.err_cnt    = r_err_cnt;

   always_ff @(posedge i_hiss_clk or negedge i_n_reset) begin
      if (!i_n_reset) begin
         r_state     <= S_IDLE;
         r_sync_sreg <= '0;
         r_word_i    <= '0;
         r_word_q    <= '0;
         r_bit_cnt   <= '0;
         r_word_cnt  <= '0;
         r_miss_cnt  <= '0;
         r_rx_i_word <= '0;
         r_rx_q_word <= '0;
         r_rx_valid  <= 1'b0;
         r_rx_sof    <= 1'b0;
         r_locked    <= 1'b0;
         r_sync_err  <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_rx_valid <= 1'b0;
         r_rx_sof   <= 1'b0;
         r_sync_err <= 1'b0;
         if (!bus.rx_en) begin
            // Output words deliberately hold their last value while disabled
            r_state    <= S_IDLE;
            r_locked   <= 1'b0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_miss_cnt <= '0;
            r_err_cnt  <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_HUNT;
               end
               S_HUNT: begin
                  r_sync_sreg <= w_sync_shift;
                  if (w_sync_shift == SYNC_PAT) begin
                     r_state    <= S_LOCKED;
                     r_locked   <= 1'b1;
                     r_bit_cnt  <= '0;
                     r_word_cnt <= '0;
                     r_miss_cnt <= '0;
                  end
               end
               S_LOCKED: begin
                  r_word_i <= w_i_shift;
                  r_word_q <= w_q_shift;
                  if (w_word_last) begin
                     r_bit_cnt   <= '0;
                     r_rx_i_word <= w_i_shift;
                     r_rx_q_word <= w_q_shift;
                     r_rx_valid  <= 1'b1;
                     r_rx_sof    <= (r_word_cnt == '0);
                     if (r_word_cnt == WC_W'(FRAME_WORDS - 1)) begin
                        r_word_cnt <= '0;
                        r_state    <= S_CHECK;
                     end else begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
               S_CHECK: begin
                  r_sync_sreg <= w_sync_shift;
                  if (w_sync_last) begin
                     r_bit_cnt <= '0;
                     if (w_sync_shift == SYNC_PAT) begin
                        r_miss_cnt <= '0;
                        r_state    <= S_LOCKED;
                     end else begin
                        r_sync_err <= 1'b1;
                        if (r_err_cnt != 8'hFF) begin
                           r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        r_miss_cnt <= w_miss_inc;
                        // Too many misses: give up the old alignment; otherwise free-wheel on it
                        if (w_miss_inc == MC_W'(MAX_MISS)) begin
                           r_state  <= S_HUNT;
                           r_locked <= 1'b0;
                        end else begin
                           r_state <= S_LOCKED;
                        end
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_hiss_rx_deser.sv
// Directed bench for hiss_rx_deser: lock, frame delivery, bad preambles, loss of lock, enable and reset.
module tb_hiss_rx_deser;
   logic clk;
   logic n_reset;
   int   n_cmp;
   int   n_err;
   int   vcount;
   int   serr_count;

   hiss_rx_deser_if #(.WORD_W(8)) bus ();

   hiss_rx_deser dut (
      .i_hiss_clk (clk),
      .i_n_reset  (n_reset),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.rx_valid === 1'b1) vcount++;
      if (bus.sync_err === 1'b1) serr_count++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic i, input logic q);
      bus.hiss_rxi = i;
      bus.hiss_rxq = q;
      @(posedge clk);
      #1;
   endtask

   // One word pair; rx_valid must be quiet for 7 bits and pulse on the 8th
   task automatic send_word(input logic [7:0] wi, input logic [7:0] wq, input logic sof,
                            input string tag);
      int early;
      early = 0;
      for (int b = 7; b >= 1; b--) begin
         send_bit(wi[b], wq[b]);
         if (bus.rx_valid !== 1'b0) early++;
      end
      send_bit(wi[0], wq[0]);
      chk({tag, "_gap"}, early, 0);
      chk({tag, "_valid"}, bus.rx_valid, 1);
      chk({tag, "_i"}, bus.rx_i_word, wi);
      chk({tag, "_q"}, bus.rx_q_word, wq);
      chk({tag, "_sof"}, bus.rx_sof, sof);
   endtask

   task automatic send_frame(input string tag);
      logic [31:0] fi;
      logic [31:0] fq;
      fi = 32'h12345678;
      fq = 32'h9ABCDEF0;
      for (int w = 0; w < 4; w++) begin
         send_word(fi[31-8*w -: 8], fq[31-8*w -: 8], (w == 0), $sformatf("%s_w%0d", tag, w));
      end
   endtask

   // Preamble while locked; Q lane held high to show it is ignored
   task automatic send_pre(input logic [7:0] p, input string tag);
      int v;
      v = 0;
      for (int b = 7; b >= 0; b--) begin
         send_bit(p[b], 1'b1);
         if (bus.rx_valid !== 1'b0) v++;
      end
      chk({tag, "_novalid"}, v, 0);
   endtask

   // Preamble in HUNT: lock must appear exactly after the last bit
   task automatic hunt_pre(input logic [7:0] p, input string tag);
      for (int b = 7; b >= 1; b--) send_bit(p[b], 1'b0);
      chk({tag, "_prelock"}, bus.locked, 0);
      send_bit(p[0], 1'b0);
      chk({tag, "_lock"}, bus.locked, 1);
   endtask

   initial begin
      int v0;
      n_cmp = 0;
      n_err = 0;
      vcount = 0;
      serr_count = 0;
      n_reset = 1'b0;
      bus.rx_en = 1'b0;
      bus.hiss_rxi = 1'b0;
      bus.hiss_rxq = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_locked", bus.locked, 0);
      chk("rst_valid", bus.rx_valid, 0);
      chk("rst_sof", bus.rx_sof, 0);
      chk("rst_serr", bus.sync_err, 0);
      chk("rst_errcnt", bus.err_cnt, 0);
      chk("rst_iword", bus.rx_i_word, 0);
      chk("rst_qword", bus.rx_q_word, 0);
      chk("rst_rxien", bus.hiss_rxien, 0);
      n_reset = 1'b1;
      @(posedge clk);
      #1;

      // Basic lock and first frame
      bus.rx_en = 1'b1;
      #1;
      chk("en_rxien", bus.hiss_rxien, 1);
      chk("en_rxqen", bus.hiss_rxqen, 1);
      send_bit(1'b0, 1'b0);
      chk("idle_hunt_locked", bus.locked, 0);
      hunt_pre(8'hA5, "t1");
      send_frame("f1");

      // Single bad preamble: free-wheel and keep delivering
      send_pre(8'h5A, "bad1");
      chk("bad1_serr", bus.sync_err, 1);
      chk("bad1_errcnt", bus.err_cnt, 1);
      chk("bad1_locked", bus.locked, 1);
      send_frame("f2");
      chk("bad1_serr_pulses", serr_count, 1);
      send_pre(8'hA5, "good1");
      chk("good1_serr", bus.sync_err, 0);
      chk("good1_locked", bus.locked, 1);
      send_frame("f3");

      // Drop rx_en mid-word
      send_pre(8'hA5, "good2");
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b1);
      bus.rx_en = 1'b0;
      #1;
      chk("dis_rxien", bus.hiss_rxien, 0);
      chk("dis_rxqen", bus.hiss_rxqen, 0);
      @(posedge clk);
      #1;
      chk("dis_locked", bus.locked, 0);
      chk("dis_errcnt", bus.err_cnt, 0);
      v0 = vcount;
      for (int k = 0; k < 16; k++) send_bit(k[0], k[1]);
      chk("dis_novalid", vcount, v0);
      chk("dis_iword_hold", bus.rx_i_word, 8'h78);
      chk("dis_qword_hold", bus.rx_q_word, 8'hF0);

      // Re-enable, lock at bit offset 3
      bus.rx_en = 1'b1;
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      hunt_pre(8'hA5, "t2");
      send_frame("f4");
      chk("off3_no_serr", serr_count, 1);

      // Three consecutive bad preambles drop lock
      send_pre(8'h00, "miss1");
      chk("miss1_errcnt", bus.err_cnt, 1);
      chk("miss1_locked", bus.locked, 1);
      send_frame("f5");
      send_pre(8'hFF, "miss2");
      chk("miss2_errcnt", bus.err_cnt, 2);
      chk("miss2_locked", bus.locked, 1);
      send_frame("f6");
      send_pre(8'h5A, "miss3");
      chk("miss3_serr", bus.sync_err, 1);
      chk("miss3_errcnt", bus.err_cnt, 3);
      chk("miss3_locked", bus.locked, 0);
      hunt_pre(8'hA5, "t4");
      send_frame("f7");
      chk("relock_errcnt", bus.err_cnt, 3);

      // Asynchronous reset mid-frame
      send_pre(8'hA5, "good3");
      send_word(8'h12, 8'h9A, 1'b1, "pre_rst");
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      n_reset = 1'b0;
      #1;
      chk("arst_locked", bus.locked, 0);
      chk("arst_errcnt", bus.err_cnt, 0);
      chk("arst_iword", bus.rx_i_word, 0);
      chk("arst_qword", bus.rx_q_word, 0);
      chk("arst_valid", bus.rx_valid, 0);
      @(negedge clk);
      n_reset = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_rel_locked", bus.locked, 0);
      hunt_pre(8'hA5, "t6");
      send_frame("f8");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
